// File: rtl/mem_access.sv
// Memory stage: drives req/ack data-memory bus for loads/stores and stalls the core (>=3 cycles/access, 0 for non-memory ops).
// MISALIGN_TRAP_EN: misaligned half/word accesses raise AddrErr instead of reaching the bus.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic [31:0] Wdata,
  output logic        BusErr,
  output logic        AddrErr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d, we_q, we_d, berr_q, berr_d, aerr_q, aerr_d;
  logic [31:0]      addr_q, addr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [3:0]       be_q, be_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;

  logic [5:0]  opc;
  logic        is_load, is_store, is_half, is_word, mis, ld_q;
  logic [3:0]  be_n;
  logic [31:0] wdat_n, load_v;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_ins;

  assign opc        = Ins[31:26];
  assign unused_ins = ^Ins[25:0];

  always_comb begin
    is_load  = opc inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_store = opc inside {OP_SB, OP_SH, OP_SW};
    is_half  = opc inside {OP_LH, OP_LHU, OP_SH};
    is_word  = opc inside {OP_LW, OP_SW};
    be_n     = 4'b1000 >> Result[1:0];
    wdat_n   = '0;
    if (is_word)      be_n = 4'b1111;
    else if (is_half) be_n = Result[1] ? 4'b0011 : 4'b1100;
    // Store data is replicated across lanes; byte enables select the target lane.
    if (is_store) begin
      if (is_word)      wdat_n = Rdata2;
      else if (is_half) wdat_n = {2{Rdata2[15:0]}};
      else              wdat_n = {4{Rdata2[7:0]}};
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign mis     = (is_half && Result[0]) || (is_word && (Result[1:0] != 2'b00));
  assign AddrErr = aerr_q;
`else
  assign mis     = 1'b0;
  assign AddrErr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    be_d    = be_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    off_d   = off_q;
    berr_d  = 1'b0;
    aerr_d  = 1'b0;
    case (state_q)
      S_IDLE: if (is_load || is_store) begin
        op_d  = opc;
        off_d = Result[1:0];
        if (mis) begin
          aerr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = {Result[31:2], 2'b00};
          be_d    = be_n;
          wdat_d  = wdat_n;
          we_d    = is_store;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_ack) begin
          rdat_d  = dmem_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdat_d  = '0;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // DONE lasts one cycle and never re-samples Ins, so an access is issued once.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      be_q    <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      off_q   <= '0;
      berr_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      be_q    <= be_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      off_q   <= off_d;
      berr_q  <= berr_d;
      aerr_q  <= aerr_d;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_v = rdat_q[31:24];
      2'd1:    byte_v = rdat_q[23:16];
      2'd2:    byte_v = rdat_q[15:8];
      default: byte_v = rdat_q[7:0];
    endcase
    half_v = off_q[1] ? rdat_q[15:0] : rdat_q[31:16];
    case (op_q)
      OP_LB:   load_v = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_v = {24'b0, byte_v};
      OP_LH:   load_v = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_v = {16'b0, half_v};
      default: load_v = rdat_q;
    endcase
  end

  assign ld_q       = op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign Stall      = ((state_q == S_IDLE) && (is_load || is_store)) || (state_q == S_REQ);
  assign Wdata      = ((state_q == S_DONE) && ld_q) ? ((berr_q || aerr_q) ? 32'h0 : load_v) : Result;
  assign BusErr     = berr_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdat_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, timeout/reset sequences, randomized ops vs a lane-level model.
module tb_mem_access;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins, Result, Rdata2, Wdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        Stall, BusErr, AddrErr, dmem_req, dmem_we, dmem_ack;
  logic [3:0]  dmem_be;

  mem_access #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .Stall(Stall), .Wdata(Wdata), .BusErr(BusErr), .AddrErr(AddrErr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int stall, reqs;
    logic [31:0] addr, wd, bw;
    logic [3:0] be;
    logic we, berr, aerr;
  } exp_t;

  typedef struct {
    int stall, reqs;
    logic [31:0] addr, wd, bw;
    logic [3:0] be;
    logic we, berr, aerr, stable, done;
  } obs_t;

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] res, rd2, rdat;
    int          dly;
    exp_t        e;
  } vec_t;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", n, act, exp);
    end
  endtask

  function automatic exp_t mk(input int stall, input int reqs, input logic [31:0] addr, wd, bw,
                              input logic [3:0] be, input logic we, berr, aerr);
    exp_t e;
    e.stall = stall; e.reqs = reqs; e.addr = addr; e.wd = wd; e.bw = bw;
    e.be = be; e.we = we; e.berr = berr; e.aerr = aerr;
    return e;
  endfunction

  // Reference: derive lanes/values from access size and byte offset (big-endian).
  function automatic exp_t model(input logic [5:0] opc, input logic [31:0] res, rd2, rdat, input int dly);
    exp_t e;
    int size, off, start;
    bit ld, st, sgn, mis;
    logic [63:0] v;
    ld = 0; st = 0; sgn = 0; size = 4;
    case (opc)
      6'h20: begin ld = 1; size = 1; sgn = 1; end
      6'h24: begin ld = 1; size = 1; end
      6'h21: begin ld = 1; size = 2; sgn = 1; end
      6'h25: begin ld = 1; size = 2; end
      6'h23: begin ld = 1; size = 4; end
      6'h28: begin st = 1; size = 1; end
      6'h29: begin st = 1; size = 2; end
      6'h2B: begin st = 1; size = 4; end
      default: ;
    endcase
    off   = int'(res[1:0]);
    start = off - (off % size);
    mis   = 0;
`ifdef MISALIGN_TRAP_EN
    mis = (off % size) != 0;
`endif
    e = mk(0, 0, {res[31:2], 2'b00}, res, 32'h0, 4'h0, st, 1'b0, 1'b0);
    if (!(ld || st)) return e;
    if (mis) begin
      e.stall = 1; e.aerr = 1'b1;
      if (ld) e.wd = 32'h0;
      return e;
    end
    for (int l = start; l < start + size; l++) e.be[3-l] = 1'b1;
    if (st)
      for (int l = 0; l < 4; l++) e.bw[8*(3-l) +: 8] = 8'(rd2 >> (8*(size - 1 - (l % size))));
    if (dly < 0) begin
      e.stall = 1 + TIMEOUT; e.reqs = TIMEOUT; e.berr = 1'b1;
      if (ld) e.wd = 32'h0;
    end else begin
      e.stall = dly + 2; e.reqs = dly + 1;
      if (ld) begin
        v = 64'(rdat >> (8*(4 - size - start))) & ((64'd1 << (8*size)) - 64'd1);
        if (sgn && v[8*size-1]) v = v - (64'd1 << (8*size));
        e.wd = v[31:0];
      end
    end
    return e;
  endfunction

  // Drive one instruction until Stall releases; ack in REQ cycle number dly (dly<0: never).
  task automatic run_op(input logic [5:0] opc, input logic [31:0] res, rd2, input int dly,
                        input logic [31:0] rdat, output obs_t o);
    o.stall = 0; o.reqs = 0; o.addr = 0; o.wd = 0; o.bw = 0; o.be = 0;
    o.we = 0; o.berr = 0; o.aerr = 0; o.stable = 1; o.done = 0;
    Ins = {opc, 26'($urandom)}; Result = res; Rdata2 = rd2; dmem_ack = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (!Stall) begin
        o.wd = Wdata; o.berr = BusErr; o.aerr = AddrErr; o.done = 1;
        if (dmem_req) o.reqs++;
        break;
      end
      o.stall++;
      if (dmem_req) begin
        if (o.reqs == 0) begin
          o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.bw = dmem_wdata;
        end else if ({dmem_addr, dmem_be, dmem_we, dmem_wdata} != {o.addr, o.be, o.we, o.bw}) begin
          o.stable = 0;
        end
        if (o.reqs == dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdat;
        end
        o.reqs++;
      end
    end
    @(posedge CLK); #1;
    dmem_ack = 1'b0;
  endtask

  task automatic cmp(input string n, input exp_t e, input obs_t o);
    chk({n, ".done"}, 32'(o.done), 32'd1);
    chk({n, ".stall"}, 32'(o.stall), 32'(e.stall));
    chk({n, ".reqs"}, 32'(o.reqs), 32'(e.reqs));
    chk({n, ".wdata"}, o.wd, e.wd);
    chk({n, ".buserr"}, 32'(o.berr), 32'(e.berr));
    chk({n, ".addrerr"}, 32'(o.aerr), 32'(e.aerr));
    if (e.reqs > 0) begin
      chk({n, ".addr"}, o.addr, e.addr);
      chk({n, ".we"}, 32'(o.we), 32'(e.we));
      chk({n, ".stable"}, 32'(o.stable), 32'd1);
      if (e.we) begin
        chk({n, ".be"}, 32'(o.be), 32'(e.be));
        chk({n, ".buswdata"}, o.bw, e.bw);
      end
    end
  endtask

  task automatic add(input logic [5:0] opc, input logic [31:0] res, rd2, rdat, input int dly, input exp_t e);
    vec_t v;
    v.opc = opc; v.res = res; v.rd2 = rd2; v.rdat = rdat; v.dly = dly; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    obs_t o;
    logic [5:0] ops [10];
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};

    RST = 1'b1; Ins = 32'h0; Result = 32'hABCD; Rdata2 = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge CLK);
    chk("rst.stall", 32'(Stall), 32'd0);
    chk("rst.wdata", Wdata, 32'hABCD);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdat", dmem_wdata, 32'd0);
    chk("rst.buserr", 32'(BusErr), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    add(6'h00, 32'h1234, 32'h0, 32'h0, 0, mk(0, 0, 0, 32'h1234, 0, 0, 0, 0, 0));
    add(6'h2B, 32'h100, 32'hDEADBEEF, 32'h0, 1, mk(3, 2, 32'h100, 32'h100, 32'hDEADBEEF, 4'b1111, 1, 0, 0));
    add(6'h20, 32'h103, 32'h0, 32'h000000F0, 0, mk(2, 1, 32'h100, 32'hFFFFFFF0, 0, 0, 0, 0, 0));
    add(6'h24, 32'h103, 32'h0, 32'h000000F0, 0, mk(2, 1, 32'h100, 32'h000000F0, 0, 0, 0, 0, 0));
    add(6'h21, 32'h102, 32'h0, 32'h1234ABCD, 2, mk(4, 3, 32'h100, 32'hFFFFABCD, 0, 0, 0, 0, 0));
    add(6'h29, 32'h102, 32'h5566, 32'h0, 0, mk(2, 1, 32'h100, 32'h102, 32'h55665566, 4'b0011, 1, 0, 0));
    add(6'h28, 32'h201, 32'h123456AB, 32'h0, 0, mk(2, 1, 32'h200, 32'h201, 32'hABABABAB, 4'b0100, 1, 0, 0));
    add(6'h25, 32'h100, 32'h0, 32'h80017FFF, 0, mk(2, 1, 32'h100, 32'h00008001, 0, 0, 0, 0, 0));
    add(6'h20, 32'h101, 32'h0, 32'h00800000, 0, mk(2, 1, 32'h100, 32'hFFFFFF80, 0, 0, 0, 0, 0));
    add(6'h23, 32'h104, 32'h0, 32'hCAFEF00D, 3, mk(5, 4, 32'h104, 32'hCAFEF00D, 0, 0, 0, 0, 0));
    add(6'h0F, 32'hFFFF0000, 32'h0, 32'h0, 0, mk(0, 0, 0, 32'hFFFF0000, 0, 0, 0, 0, 0));
`ifdef MISALIGN_TRAP_EN
    add(6'h23, 32'h101, 32'h0, 32'hCAFEF00D, 0, mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 1));
    add(6'h21, 32'h101, 32'h0, 32'h9ABC0000, 0, mk(1, 0, 0, 32'h0, 0, 0, 0, 0, 1));
`else
    add(6'h23, 32'h101, 32'h0, 32'hCAFEF00D, 0, mk(2, 1, 32'h100, 32'hCAFEF00D, 0, 0, 0, 0, 0));
    add(6'h21, 32'h101, 32'h0, 32'h9ABC0000, 0, mk(2, 1, 32'h100, 32'hFFFF9ABC, 0, 0, 0, 0, 0));
`endif
    // Timeout, then a non-memory op whose BusErr must already be low again.
    add(6'h23, 32'h300, 32'h0, 32'h55555555, -1, mk(17, 16, 32'h300, 32'h0, 0, 0, 0, 1, 0));
    add(6'h00, 32'h42, 32'h0, 32'h0, 0, mk(0, 0, 0, 32'h42, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      run_op(vecs[i].opc, vecs[i].res, vecs[i].rd2, vecs[i].dly, vecs[i].rdat, o);
      cmp($sformatf("vec%0d", i), vecs[i].e, o);
    end

    // Ack outside REQ must not start or disturb anything.
    Ins = 32'h0; Result = 32'h99; dmem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("stray_ack.req", 32'(dmem_req), 32'd0);
      chk("stray_ack.wdata", Wdata, 32'h99);
    end
    @(posedge CLK); #1;
    dmem_ack = 1'b0;

    // Reset in the middle of an outstanding load.
    Ins = {6'h23, 26'h0}; Result = 32'h400;
    for (int c = 0; c < 8 && !dmem_req; c++) @(negedge CLK);
    chk("midrst.req_seen", 32'(dmem_req), 32'd1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("midrst.req", 32'(dmem_req), 32'd0);
    chk("midrst.addr", dmem_addr, 32'd0);
    Ins = 32'h0; Result = 32'h77;
    #1;
    chk("midrst.stall", 32'(Stall), 32'd0);
    chk("midrst.wdata", Wdata, 32'h77);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    run_op(6'h23, 32'h500, 32'h0, 0, 32'h01020304, o);
    cmp("after_rst", mk(2, 1, 32'h500, 32'h01020304, 0, 0, 0, 0, 0), o);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] opc;
      logic [31:0] res, rd2, rdat;
      int dly;
      opc  = ops[$urandom_range(0, 9)];
      res  = $urandom;
      rd2  = $urandom;
      rdat = $urandom;
      dly  = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
      run_op(opc, res, rd2, dly, rdat, o);
      cmp($sformatf("rnd%0d_op%02h", i, opc), model(opc, res, rd2, rdat, dly), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage. Consumes the instruction word, the ALU Result (effective address) and Rdata2 (store data).
- Drives a req/ack data-memory bus for LB/LBU/LH/LHU/LW/SB/SH/SW and stalls the core until the access completes.
- Returns the write-back value: load data, or Result passed through for non-memory instructions.

Parameters:
- TIMEOUT, 16, max cycles to wait for dmem_ack before aborting with bus error (1..255).
- CNT_W, 8, width of timeout counter.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous active-high reset
- Ins  input  32  current instruction (opcode Ins[31:26])
- Result  input  32  execute-stage result; effective address for memory ops
- Rdata2  input  32  store data (rt)
- Stall  output  1  high while access outstanding; core holds PC/Ins
- Wdata  output  32  write-back value
- BusErr  output  1  one-cycle pulse: access aborted by timeout
- AddrErr  output  1  misaligned-access flag (MISALIGN_TRAP_EN only, else tied 0)
- dmem_req  output  1  bus request
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word address {Result[31:2],2'b00}
- dmem_wdata  output  32  lane-positioned store data
- dmem_be  output  4  byte enables, be[3] = bits 31:24
- dmem_ack  input  1  bus completes access this cycle
- dmem_rdata  input  32  read data, valid with dmem_ack

Behaviour:
- Reset (async, RST=1): state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, load register=0, counter=0, BusErr=0. Stall and Wdata are combinational from state.
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Any other opcode is non-memory.
- Byte order is big-endian: byte offset 0 is bits 31:24.
- FSM states: IDLE, REQ, DONE.
- IDLE, non-memory op:
  - Stall=0, Wdata=Result combinationally.
  - Zero latency, no bus activity.
- IDLE, memory op:
  - Stall=1 combinationally.
  - At the next edge: register address, be, wdata and we; assert dmem_req; clear counter; go to REQ.
- REQ:
  - dmem_req held high with all bus outputs stable; Stall=1.
  - On dmem_ack: capture dmem_rdata, drop dmem_req at the edge, go to DONE.
  - Otherwise increment counter. When counter reaches TIMEOUT-1 without ack: drop req, set error, go to DONE.
- DONE:
  - Stall=0 for exactly one cycle; core advances at this edge.
  - Wdata = extracted load value for loads, Result for stores.
  - BusErr=1 for this cycle if timed out; load Wdata is then 0.
  - Next state IDLE. Ins is not re-sampled in DONE, so the same access is never issued twice.
- Load extraction, by Result[1:0]:
  - LB/LBU: byte at offset; sign- or zero-extended to 32.
  - LH/LHU: halfword at Result[1] (0 = bits 31:16); sign- or zero-extended.
  - LW: full word.
- Store positioning:
  - SB: Rdata2[7:0] replicated to all lanes; be one-hot per offset (offset 0 gives 1000).
  - SH: Rdata2[15:0] replicated; be 1100 or 0011.
  - SW: be 1111.
- dmem_ack outside REQ is ignored.
- Back-to-back memory ops: DONE is followed by IDLE, which immediately accepts the next op. Throughput is at best 3 cycles per access (ack in first REQ cycle).
- Reset mid-access: abandons the transfer immediately; dmem_req drops asynchronously.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned halfword (Result[0]=1) or word (Result[1:0]≠0) access issues no bus request.
  - FSM goes IDLE→DONE directly.
  - AddrErr=1 in DONE; load Wdata=0; store writes nothing.
- Undefined:
  - Low address bits ignored: halfword uses Result[1], word uses the aligned word.
  - AddrErr tied 0.

Test Plan:
- ADDU, Result=0x1234 → Stall=0 same cycle, Wdata=0x1234, dmem_req never asserts.
- SW, Result=0x100, Rdata2=0xDEADBEEF, ack 2 cycles after req → dmem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; Stall high 3 cycles then low 1 cycle.
- LB, Result=0x103, rdata=0x000000F0 → Wdata=0xFFFFFFF0. LBU same access → Wdata=0x000000F0.
- LH, Result=0x102, rdata=0x1234ABCD → Wdata=0xFFFFABCD. SH, Result=0x102, Rdata2=0x5566 → be=0011, wdata=0x55665566.
- LW, dmem_ack never asserted, TIMEOUT=16 → req drops after 16 cycles, BusErr pulses 1 cycle, Wdata=0, Stall releases. RST asserted mid-REQ → dmem_req=0 immediately, state IDLE.
- MISALIGN_TRAP_EN defined, LW Result=0x101 → no dmem_req, AddrErr=1 in DONE, Wdata=0. Macro undefined → access issued to 0x100.
